frame_buffer_writer: RTL
========================

# frame_buffer_writer

Ingress-side write controller for the switch's shared packet `ram`. It accepts a byte stream of Ethernet frames from the MAC receive path and writes each byte into the `ram` write port at consecutive circular addresses. For every good frame it publishes a descriptor (start address, length) downstream. Frames that end with an error, or that exceed the buffer, are discarded by rewinding the write pointer, and buffer occupancy is returned by the downstream reader through a release port.

## Interface
- `WIDTH`, 8: data width in bits; must match `ram` WIDTH.
- `DEPTH`, 2048: `ram` depth in entries; must be a power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)`: address width (derived).
- `LW`, `$clog2(DEPTH)+1`: length/occupancy width (derived); holds the value DEPTH.

Ports:
- `clock`  in  1  single clock domain; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  upstream beat accepted when `in_valid && in_ready`.
- `in_data`  in  WIDTH  frame byte.
- `in_last`  in  1  final beat of the frame.
- `in_error`  in  1  frame bad; sampled on the `in_last` beat only.
- `write_vaild`  out  1  `ram` write request.
- `write_ready`  in  1  `ram` accepts the write this cycle.
- `write_address`  out  AW  `ram` write address.
- `write_data`  out  WIDTH  `ram` write data.
- `desc_valid`  out  1  descriptor available.
- `desc_ready`  in  1  descriptor consumed.
- `desc_start`  out  AW  address of the frame's first byte.
- `desc_length`  out  LW  frame length in bytes (1..DEPTH).
- `release_valid`  in  1  reader frees `release_length` entries.
- `release_length`  in  LW  entries freed; never exceeds committed occupancy.
- `drop_count`  out  16  saturating count of discarded frames.

## Operation
- State: `wr_ptr` (AW), `frame_start` (AW), `frame_len` (LW), `used` (LW, counts committed plus in-progress bytes), and FSM {IDLE, WRITE, DESC, DROP}.
- `space = (used != DEPTH)`.
- Accept condition in IDLE or WRITE: `write_vaild = in_valid && space`; `in_ready = write_ready && space`. The block writes a byte when `in_valid && in_ready`. `write_address = wr_ptr` and `write_data = in_data` are combinational pass-through.
- On each written byte:
  - `wr_ptr` increments modulo DEPTH (DEPTH-1 wraps to 0).
  - `frame_len` increments.
  - `used` increments.
- IDLE: the first written byte sets `frame_start = wr_ptr` and moves to WRITE. If that byte has `in_last` set, the 1-byte frame is handled per the `in_last` rules below.
- WRITE: when `used == DEPTH` and `frame_len < DEPTH`, the block stalls (`in_ready=0`) and waits for a release.
- `in_last` written with `in_error=0`: go to DESC.
- `in_last` written with `in_error=1`: discard the frame:
  - `wr_ptr ← frame_start`;
  - `used ← used - frame_len` (including the final byte);
  - `drop_count` increments;
  - go to IDLE.
- Oversize: in WRITE, when `frame_len == DEPTH` and `in_valid` is high without a preceding last, go to DROP. On entry, rewind `wr_ptr`/`used` the same way and increment `drop_count`.
- DROP: `in_ready=1`, `write_vaild=0`, beats are discarded. When `in_last` is accepted, go to IDLE.
- DESC: `in_ready=0`, `write_vaild=0`, `desc_valid=1`, `desc_start=frame_start`, `desc_length=frame_len`; these hold stable until `desc_ready`. On `desc_valid && desc_ready`: `frame_len ← 0`, go to IDLE.
- Release: when `release_valid` is high, `used ← used - release_length`. A release and a byte write in the same cycle apply net (`used - release_length + 1`). A release in the same cycle as an error rewind applies both.
- `drop_count` saturates at 0xFFFF.

## Timing
- Reset values: FSM=IDLE; `wr_ptr`, `frame_start`, `frame_len`, `used` = 0; `desc_valid=0`; `drop_count=0`. `in_ready=0` and `write_vaild=0` while `reset` is high.
- Write latency is zero: the upstream beat and the `ram` write occur in the same cycle.
- `desc_valid` rises the cycle after the good `in_last` is accepted.
- Back-to-back frames: minimum one idle cycle (DESC) between frames.
- Reset asserted mid-frame or mid-DESC: all state clears immediately, and the partial frame and pending descriptor are lost.
- Stall released by a same-cycle `release_valid` takes effect the next cycle, because `space` is computed from registered `used`.

## Test plan
- Reset, then frame 0x11,0x22,0x33,0x44 (last on 0x44) with `write_ready=1` -> writes at addresses 0..3 on consecutive cycles; next cycle `desc_valid=1`, `desc_start=0`, `desc_length=4`.
- Same frame with `write_ready` low for 3 cycles after byte 2 -> `in_ready=0` for those cycles; no address skipped; descriptor still start=0, length=4.
- 3-byte frame with `in_error=1` on last -> no `desc_valid`, `drop_count=1`; next 2-byte frame writes addresses 0,1 with `desc_start=0`.
- DEPTH=8: commit a 6-byte frame, release 6, then a 4-byte frame -> addresses 6,7,0,1; `desc_start=6`, `desc_length=4`.
- DEPTH=8: commit 6 bytes, no release, then a 4-byte frame -> 2 bytes written then `in_ready=0`. Pulse `release_valid` with `release_length=6` -> writing resumes one cycle later; descriptor start=6, length=4.
- DEPTH=8, empty buffer, 10-byte frame -> 8 bytes written, remaining 2 accepted without writes; `drop_count=1`, no descriptor; `used` returns to 0.

Source files
------------

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: writes an ingress byte stream into a circular packet ram and publishes per-frame descriptors
// Ports:
//   clock, reset                         clock and asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last/in_error   upstream frame byte stream
//   write_vaild/write_ready/write_address/write_data   ram write port (zero-latency pass-through)
//   desc_valid/desc_ready/desc_start/desc_length       descriptor of each good frame
//   release_valid/release_length         reader returns committed entries
//   drop_count                           saturating count of discarded frames
module frame_buffer_writer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2048,
   parameter int AW = $clog2(DEPTH),
   parameter int LW = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_error,
   output logic             write_vaild,
   input  logic             write_ready,
   output logic [AW-1:0]    write_address,
   output logic [WIDTH-1:0] write_data,
   output logic             desc_valid,
   input  logic             desc_ready,
   output logic [AW-1:0]    desc_start,
   output logic [LW-1:0]    desc_length,
   input  logic             release_valid,
   input  logic [LW-1:0]    release_length,
   output logic [15:0]      drop_count
);
   typedef enum logic [1:0] {IDLE, WRITE, DESC, DROP} state_t;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, start_q, start_d;
   logic [LW-1:0] len_q, len_d, used_q, used_d, len_n;
   logic [15:0] drop_q, drop_d;
   logic accepting, space, wr, over, bad, good, discard;
   // space comes from registered occupancy, so a release only unblocks the next cycle
   assign space = used_q != FULL;
   assign accepting = !reset && (state_q == IDLE || state_q == WRITE);
   assign write_vaild = accepting && in_valid && space;
   assign in_ready = !reset && (state_q == DROP || (accepting && write_ready && space));
   assign wr = write_vaild && write_ready;
   // a full-length frame that keeps going can never fit: abandon it
   assign over = state_q == WRITE && len_q == FULL && in_valid;
   assign bad = wr && in_last && in_error;
   assign good = wr && in_last && !in_error;
   assign discard = bad || over;
   assign len_n = len_q + LW'(wr);
   assign write_address = wr_ptr_q;
   assign write_data = in_data;
   assign desc_valid = state_q == DESC;
   assign desc_start = start_q;
   assign desc_length = len_q;
   assign drop_count = drop_q;
   always_comb begin
      start_d = (wr && state_q == IDLE) ? wr_ptr_q : start_q;
      wr_ptr_d = discard ? start_d : wr_ptr_q + AW'(wr);
      used_d = used_q + LW'(wr) - (release_valid ? release_length : '0) - (discard ? len_n : '0);
      len_d = (discard || (state_q == DESC && desc_ready)) ? '0 : len_n;
      drop_d = (discard && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      state_d = over ? DROP :
                good ? DESC :
                bad ? IDLE :
                (state_q == IDLE && wr) ? WRITE :
                (state_q == DESC && desc_ready) ? IDLE :
                (state_q == DROP && in_valid && in_last) ? IDLE : state_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         start_q <= '0;
         len_q <= '0;
         used_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         start_q <= start_d;
         len_q <= len_d;
         used_q <= used_d;
         drop_q <= drop_d;
      end
   end
endmodule
